// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for a multi-digit
// seven-segment display. One digit is enabled per slot; each slot is split
// into 16 sub-slots of TICK_DIV cycles. Sub-slot 0 is always blank so the
// segment bus can settle between digits, and sub-slots 1..brightness are lit.
// The segment pattern is captured once per frame so a display update never
// tears across digits.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS = 6,
    parameter int TICK_DIV   = 3125
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [8*NUM_DIGITS-1:0] seg_data,
    input  logic [3:0]              brightness,
    output logic [NUM_DIGITS-1:0]   led_en,
    output logic [7:0]              led_seg,
    output logic                    frame_done
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t                  state;
    logic [TW-1:0]           tick;
    logic [TW-1:0]           tick_n;
    logic [3:0]              sub;
    logic [3:0]              sub_n;
    logic [IW-1:0]           idx;
    logic [IW-1:0]           idx_n;
    logic                    frame_wrap;
    logic [8*NUM_DIGITS-1:0] snapshot;
    logic [NUM_DIGITS-1:0]   en_n;
    logic [7:0]              seg_n;

    // Next values of the tick / sub-slot / digit counters and the frame wrap.
    always_comb begin
        tick_n     = tick + 1'b1;
        sub_n      = sub;
        idx_n      = idx;
        frame_wrap = 1'b0;
        if (tick == TW'(TICK_DIV - 1)) begin
            tick_n = '0;
            sub_n  = sub + 4'd1;
            if (sub == 4'd15) begin
                if (idx == IW'(NUM_DIGITS - 1)) begin
                    idx_n      = '0;
                    frame_wrap = 1'b1;
                end else begin
                    idx_n = idx + 1'b1;
                end
            end
        end
    end

    // Output decode from the post-update counters, so the registered outputs
    // line up with the counters without an extra cycle of lag.
    always_comb begin
        en_n  = '1;
        seg_n = 8'hFF;
        if (sub_n != 4'd0 && sub_n <= brightness) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (idx_n == IW'(i)) begin
                    en_n[i] = 1'b0;
                    seg_n   = snapshot[8*i +: 8];
                end
            end
        end
    end

    // Scan state machine: counters, frame snapshot and registered pin drivers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            tick       <= '0;
            sub        <= '0;
            idx        <= '0;
            snapshot   <= '1;
            led_en     <= '1;
            led_seg    <= 8'hFF;
            frame_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    tick       <= '0;
                    sub        <= '0;
                    idx        <= '0;
                    led_en     <= '1;
                    led_seg    <= 8'hFF;
                    frame_done <= 1'b0;
                    if (en) begin
                        state    <= SCAN;
                        snapshot <= seg_data;
                    end
                end
                SCAN: begin
                    if (!en) begin
                        // Abandon the slot immediately; no partial completion.
                        state      <= IDLE;
                        tick       <= '0;
                        sub        <= '0;
                        idx        <= '0;
                        led_en     <= '1;
                        led_seg    <= 8'hFF;
                        frame_done <= 1'b0;
                    end else begin
                        tick       <= tick_n;
                        sub        <= sub_n;
                        idx        <= idx_n;
                        led_en     <= en_n;
                        led_seg    <= seg_n;
                        frame_done <= frame_wrap;
                        if (frame_wrap) begin
                            snapshot <= seg_data;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
